matmat_seq: RTL and testbench

//   Parametrised sequential fixed-point NxN matrix multiplier, mul = A x B, for the navigation datapath.

---
 rtl/matmat_pkg.sv | 51 +++++
 rtl/matmat_seq_fxp_mac.sv | 31 +++
 rtl/matmat_seq.sv | 149 ++++++++++++++
 tb/tb_matmat_seq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/matmat_pkg.sv
// Shared types and fixed-point helpers for the sequential NxN matrix multiplier.
// Fixed-point formatting honours the MATMAT_SAT_EN build option (clamp instead of wrap).
package matmat_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MAC   = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Wide enough to hold any accumulator this block can be configured for.
  localparam int FMT_W = 128;

  function automatic int acc_width(input int dw, input int n);
    return 2 * dw + $clog2(n) + 1;
  endfunction

  function automatic logic signed [FMT_W-1:0] sat_hi(input int dw);
    return (128'sd1 <<< (dw - 1)) - 128'sd1;
  endfunction

  function automatic logic signed [FMT_W-1:0] sat_lo(input int dw);
    return -(128'sd1 <<< (dw - 1));
  endfunction

  function automatic logic sat_hit(input logic signed [FMT_W-1:0] acc, input int dw, input int bp);
    logic signed [FMT_W-1:0] sh;
    sh = acc >>> bp;
    return (sh > sat_hi(dw)) || (sh < sat_lo(dw));
  endfunction

  // Shift out the fraction (toward -inf), then clamp or wrap to dw bits, sign-extended.
  function automatic logic signed [FMT_W-1:0] fmt(input logic signed [FMT_W-1:0] acc, input int dw, input int bp);
    logic signed [FMT_W-1:0] sh;
    sh = acc >>> bp;
`ifdef MATMAT_SAT_EN
    if (sh > sat_hi(dw)) begin
      sh = sat_hi(dw);
    end else if (sh < sat_lo(dw)) begin
      sh = sat_lo(dw);
    end else begin
      sh = sh;
    end
`endif
    sh = sh <<< (FMT_W - dw);
    return sh >>> (FMT_W - dw);
  endfunction

endpackage

// File: rtl/matmat_seq_fxp_mac.sv
// Registered signed multiply-accumulate: one product per enabled cycle,
// clear restarts the sum with the current product.
module fxp_mac #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 34
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_clr,
  input  logic                         i_en,
  input  logic signed [DATA_WIDTH-1:0] i_a,
  input  logic signed [DATA_WIDTH-1:0] i_b,
  output logic signed [ACC_WIDTH-1:0]  o_acc
);

  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0]    w_prod_ext;

  assign w_prod     = i_a * i_b;
  assign w_prod_ext = {{(ACC_WIDTH - 2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};

  // Accumulator register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_acc <= '0;
    end else if (i_en) begin
      o_acc <= (i_clr ? '0 : o_acc) + w_prod_ext;
    end
  end

endmodule

// File: rtl/matmat_seq.sv
// Sequential fixed-point NxN matrix multiplier (mul = A x B), one MAC per cycle.
// Build option MATMAT_SAT_EN: saturate results and expose a sticky sat_flag.
module matmat_seq
  import matmat_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int BIN_POS     = 8,
  parameter int MATRIX_SIZE = 2
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
  output logic                                          busy,
  output logic                                          complete,
  input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] matrix_a,
  input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] matrix_b,
  output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] mul
`ifdef MATMAT_SAT_EN
  ,
  output logic                                          sat_flag
`endif
);

  localparam int N  = MATRIX_SIZE;
  localparam int DW = DATA_WIDTH;
  localparam int AW = acc_width(DW, N);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int VW = N * N * DW;

  state_t                  r_state, w_next;
  logic [IW-1:0]           r_i, r_j, r_k;
  logic [VW-1:0]           r_a, r_b;
  logic                    w_accept, w_mac_en, w_mac_clr, w_write;
  logic                    w_k_last, w_j_last, w_last_el;
  logic signed [DW-1:0]    w_a_el, w_b_el;
  logic signed [AW-1:0]    w_acc;
  logic signed [FMT_W-1:0] w_acc_ext;
  logic [DW-1:0]           w_el;

  assign w_k_last  = (r_k == IW'(N - 1));
  assign w_j_last  = (r_j == IW'(N - 1));
  assign w_last_el = w_j_last && (r_i == IW'(N - 1));
  assign w_a_el    = r_a[(int'(r_i) * N + int'(r_k)) * DW +: DW];
  assign w_b_el    = r_b[(int'(r_k) * N + int'(r_j)) * DW +: DW];
  assign w_acc_ext = FMT_W'(w_acc);
  assign w_el      = DW'(fmt(w_acc_ext, DW, BIN_POS));

  fxp_mac #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) u_mac (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_mac_clr),
    .i_en  (w_mac_en),
    .i_a   (w_a_el),
    .i_b   (w_b_el),
    .o_acc (w_acc)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? LOAD : IDLE;
      LOAD:    w_next = MAC;
      MAC:     w_next = w_k_last ? WRITE : MAC;
      WRITE:   w_next = w_last_el ? DONE : MAC;
      DONE:    w_next = start ? LOAD : DONE;
      default: w_next = IDLE;
    endcase
  end

  // Per-state control strobes
  always_comb begin
    w_accept  = 1'b0;
    w_mac_en  = 1'b0;
    w_mac_clr = 1'b0;
    w_write   = 1'b0;
    case (r_state)
      IDLE, DONE: w_accept = start;
      MAC: begin
        w_mac_en  = 1'b1;
        w_mac_clr = (r_k == '0);
      end
      WRITE:   w_write = 1'b1;
      default: w_write = 1'b0;
    endcase
  end

  // Operand capture, index walk, result write-back and handshake flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_k      <= '0;
      busy     <= 1'b0;
      complete <= 1'b0;
      mul      <= '0;
    end else if (w_accept) begin
      r_a      <= matrix_a;
      r_b      <= matrix_b;
      r_i      <= '0;
      r_j      <= '0;
      r_k      <= '0;
      busy     <= 1'b1;
      complete <= 1'b0;
    end else if (w_mac_en) begin
      r_k <= w_k_last ? '0 : r_k + IW'(1);
    end else if (w_write) begin
      mul[(int'(r_i) * N + int'(r_j)) * DW +: DW] <= w_el;
      if (w_j_last) begin
        r_j <= '0;
        r_i <= w_last_el ? '0 : r_i + IW'(1);
      end else begin
        r_j <= r_j + IW'(1);
      end
      if (w_last_el) begin
        busy     <= 1'b0;
        complete <= 1'b1;
      end
    end
  end

`ifdef MATMAT_SAT_EN
  logic w_sat;
  assign w_sat = sat_hit(w_acc_ext, DW, BIN_POS);

  // Sticky clamp indicator for the current job
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_flag <= 1'b0;
    end else if (w_accept) begin
      sat_flag <= 1'b0;
    end else if (w_write && w_sat) begin
      sat_flag <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_matmat_seq.sv
// Randomised self-checking bench for matmat_seq: a 2x2 Q8.8 instance and a 3x3 Q12.12
// instance, both checked against a plain-arithmetic matrix product model.
module tb_matmat_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         s2_start, busy2, cmp2;
  logic [63:0]  a2, b2, m2;
  logic         s3_start, busy3, cmp3;
  logic [215:0] a3, b3, m3;
`ifdef MATMAT_SAT_EN
  logic sat2, sat3;
`endif

  matmat_seq #(.DATA_WIDTH(16), .BIN_POS(8), .MATRIX_SIZE(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(s2_start), .busy(busy2), .complete(cmp2),
    .matrix_a(a2), .matrix_b(b2), .mul(m2)
`ifdef MATMAT_SAT_EN
    , .sat_flag(sat2)
`endif
  );

  matmat_seq #(.DATA_WIDTH(24), .BIN_POS(12), .MATRIX_SIZE(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(s3_start), .busy(busy3), .complete(cmp3),
    .matrix_a(a3), .matrix_b(b3), .mul(m3)
`ifdef MATMAT_SAT_EN
    , .sat_flag(sat3)
`endif
  );

  longint ga [3][3];
  longint gb [3][3];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int dw_of(input int n);
    return (n == 2) ? 16 : 24;
  endfunction

  function automatic int bp_of(input int n);
    return (n == 2) ? 8 : 12;
  endfunction

  // Reference: row-by-column dot product, floor-shift, then wrap or clamp to dw bits.
  function automatic longint ref_el(input int n, input int r, input int c, output bit sat);
    longint s, hi, lo;
    int dw, bp;
    dw = dw_of(n);
    bp = bp_of(n);
    s  = 0;
    for (int k = 0; k < n; k++) s += ga[r][k] * gb[k][c];
    s   = s >>> bp;
    hi  = (64'sd1 <<< (dw - 1)) - 1;
    lo  = -hi - 1;
    sat = 1'b0;
`ifdef MATMAT_SAT_EN
    if (s > hi) begin s = hi; sat = 1'b1; end
    else if (s < lo) begin s = lo; sat = 1'b1; end
`endif
    return s & ((64'sd1 <<< dw) - 1);
  endfunction

  function automatic longint sx(input longint v, input int dw);
    longint m;
    m = v & ((64'sd1 <<< dw) - 1);
    return (m >= (64'sd1 <<< (dw - 1))) ? m - (64'sd1 <<< dw) : m;
  endfunction

  function automatic longint get_el(input int n, input int r, input int c);
    return (n == 2) ? longint'(m2[(r*2+c)*16 +: 16]) : longint'(m3[(r*3+c)*24 +: 24]);
  endfunction

  function automatic logic get_cmp(input int n);
    return (n == 2) ? cmp2 : cmp3;
  endfunction

  function automatic logic get_busy(input int n);
    return (n == 2) ? busy2 : busy3;
  endfunction

  task automatic set_start(input int n, input logic v);
    if (n == 2) s2_start = v;
    else s3_start = v;
  endtask

  task automatic rand_fill(input int n);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        ga[r][c] = sx(longint'($urandom), dw_of(n));
        gb[r][c] = sx(longint'($urandom), dw_of(n));
      end
  endtask

  task automatic drive_ops(input int n);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        if (n == 2) begin
          a2[(r*2+c)*16 +: 16] = ga[r][c][15:0];
          b2[(r*2+c)*16 +: 16] = gb[r][c][15:0];
        end else begin
          a3[(r*3+c)*24 +: 24] = ga[r][c][23:0];
          b3[(r*3+c)*24 +: 24] = gb[r][c][23:0];
        end
  endtask

  task automatic scramble_a(input int n);
    if (n == 2) a2 = {$urandom, $urandom};
    else for (int w = 0; w < 9; w++) a3[w*24 +: 24] = 24'($urandom);
  endtask

  // One job: start, optional disturbance while busy, latency and result checks.
  task automatic run_job(input int n, input string tag, input bit disturb);
    int  lat, exp_lat;
    bit  s, sat_any;
    exp_lat = 1 + n * n * (n + 1);
    drive_ops(n);
    @(negedge clk);
    set_start(n, 1'b1);
    @(posedge clk);
    #1;
    set_start(n, 1'b0);
    check({tag, "_busy_on"}, longint'(get_busy(n)), 1);
    check({tag, "_cmp_clr"}, longint'(get_cmp(n)), 0);
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (disturb && lat == 1) scramble_a(n);
      if (disturb && lat == 4) set_start(n, 1'b1);
      if (disturb && lat == 5) set_start(n, 1'b0);
      if (get_cmp(n)) break;
    end
    set_start(n, 1'b0);
    check({tag, "_latency"}, longint'(lat), longint'(exp_lat));
    check({tag, "_busy_off"}, longint'(get_busy(n)), 0);
    sat_any = 1'b0;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        check($sformatf("%s_el%0d%0d", tag, r, c), get_el(n, r, c), ref_el(n, r, c, s));
        sat_any |= s;
      end
`ifdef MATMAT_SAT_EN
    check({tag, "_sat"}, longint'((n == 2) ? sat2 : sat3), longint'(sat_any));
`endif
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_cmp_hold"}, longint'(get_cmp(n)), 1);
  endtask

  task automatic fill_const(input longint av, input longint bv);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        ga[r][c] = av;
        gb[r][c] = bv;
      end
  endtask

  initial begin
    rst = 1'b0;
    s2_start = 1'b0; s3_start = 1'b0;
    a2 = '0; b2 = '0; a3 = '0; b3 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", longint'(busy2), 0);
    check("rst_cmp", longint'(cmp2), 0);
    check("rst_mul", longint'(m2), 0);
    check("rst_busy3", longint'(busy3), 0);
`ifdef MATMAT_SAT_EN
    check("rst_sat", longint'(sat2), 0);
`endif
    rst = 1'b1;

    ga[0][0] = 64'sh100; ga[0][1] = 0; ga[1][0] = 0; ga[1][1] = 64'sh100;
    gb[0][0] = 64'sh180; gb[0][1] = 64'sh200; gb[1][0] = -256; gb[1][1] = 64'sh40;
    run_job(2, "ident", 1'b0);

    fill_const(64'sh200, 64'sh300);
    run_job(2, "uniform", 1'b0);

    fill_const(0, 0);
    ga[0][0] = -384; ga[1][1] = -384; gb[0][0] = 512; gb[1][1] = 512;
    run_job(2, "sign", 1'b0);

    fill_const(64'sh7F00, 64'sh7F00);
    run_job(2, "ovf", 1'b0);

    rand_fill(2);
    drive_ops(2);
    @(negedge clk);
    s2_start = 1'b1;
    @(posedge clk);
    #1;
    s2_start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_busy", longint'(busy2), 0);
    check("midrst_cmp", longint'(cmp2), 0);
    check("midrst_mul", longint'(m2), 0);
    @(negedge clk);
    rst = 1'b1;
    run_job(2, "after_rst", 1'b0);

    rand_fill(2);
    run_job(2, "hs2", 1'b1);
    for (int t = 0; t < 3; t++) begin
      rand_fill(2);
      run_job(2, $sformatf("rnd2_%0d", t), 1'b0);
    end

    rand_fill(3);
    run_job(3, "hs3", 1'b1);
    for (int t = 0; t < 3; t++) begin
      rand_fill(3);
      run_job(3, $sformatf("rnd3_%0d", t), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
